// File: rtl/audio_pll_seq_pkg.sv
// Shared types and defaults for the audio PLL reset sequencer.
package audio_pll_seq_pkg;

  typedef enum logic [2:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAULT     = 3'd4
  } seq_state_t;

  localparam int DEF_RST_PULSE_CYCLES    = 16;
  localparam int DEF_LOCK_STABLE_CYCLES  = 1024;
  localparam int DEF_LOCK_TIMEOUT_CYCLES = 262144;
  localparam int DEF_MAX_RETRIES         = 3;
  localparam int LOSS_CNT_W              = 8;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/audio_pll_reset_sequencer_bit_sync.sv
// Two-flop synchronizer for a single asynchronous level; resets to 0.
module bit_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/audio_pll_reset_sequencer.sv
// Audio PLL reset/lock sequencer with bounded retries and a sticky fault.
// Lock-loss counter is built only when AUDIO_PLL_SEQ_LOSS_CNT_EN is defined.
module audio_pll_reset_sequencer
  import audio_pll_seq_pkg::*;
#(
  parameter int RST_PULSE_CYCLES    = DEF_RST_PULSE_CYCLES,
  parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
  parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
  parameter int MAX_RETRIES         = DEF_MAX_RETRIES
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic                               pll_locked,
  input  logic                               restart,
  output logic                               pll_rst,
  output logic                               audio_reset_n,
  output logic                               ready,
  output logic                               fault,
  output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_count,
  output logic [LOSS_CNT_W-1:0]              lock_loss_count
);

  localparam int CNT_W = $clog2(max3(RST_PULSE_CYCLES, LOCK_STABLE_CYCLES,
                                     LOCK_TIMEOUT_CYCLES)) + 1;
  localparam int RC_W  = $clog2(MAX_RETRIES+1);

  localparam logic [CNT_W-1:0] CNT_RST = CNT_W'(RST_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_TO  = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [RC_W-1:0]  RC_MAX  = RC_W'(MAX_RETRIES);

  logic             locked_s;
  seq_state_t       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [RC_W-1:0]  retry_nxt;

  bit_sync u_lock_sync (
    .clk   (clk),
    .rst_n (reset_n),
    .d     (pll_locked),
    .q     (locked_s)
  );

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    retry_nxt = retry_count;
    if (restart) begin
      state_nxt = RESET_PLL;
      cnt_nxt   = CNT_RST;
      retry_nxt = '0;
    end else begin
      case (state)
        RESET_PLL: begin
          if (cnt == '0) begin
            state_nxt = WAIT_LOCK;
            cnt_nxt   = CNT_TO;
          end else begin
            cnt_nxt = cnt - CNT_W'(1);
          end
        end
        WAIT_LOCK: begin
          // Lock wins over a timeout landing on the same cycle.
          if (locked_s) begin
            state_nxt = STABLE;
            cnt_nxt   = CNT_ST;
          end else if (cnt == '0) begin
            if (retry_count < RC_MAX) begin
              retry_nxt = retry_count + RC_W'(1);
              state_nxt = RESET_PLL;
              cnt_nxt   = CNT_RST;
            end else begin
              state_nxt = FAULT;
            end
          end else begin
            cnt_nxt = cnt - CNT_W'(1);
          end
        end
        STABLE: begin
          if (!locked_s) begin
            state_nxt = WAIT_LOCK;
            cnt_nxt   = CNT_TO;
          end else if (cnt == '0) begin
            state_nxt = RUN;
            retry_nxt = '0;
          end else begin
            cnt_nxt = cnt - CNT_W'(1);
          end
        end
        RUN: begin
          if (!locked_s) begin
            state_nxt = RESET_PLL;
            cnt_nxt   = CNT_RST;
          end
        end
        FAULT: begin
          state_nxt = FAULT;
        end
        default: begin
          state_nxt = RESET_PLL;
          cnt_nxt   = CNT_RST;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they move with the state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= RESET_PLL;
      cnt           <= CNT_RST;
      retry_count   <= '0;
      pll_rst       <= 1'b1;
      audio_reset_n <= 1'b0;
      ready         <= 1'b0;
      fault         <= 1'b0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      retry_count   <= retry_nxt;
      pll_rst       <= (state_nxt == RESET_PLL) || (state_nxt == FAULT);
      audio_reset_n <= (state_nxt == RUN);
      ready         <= (state_nxt == RUN);
      fault         <= (state_nxt == FAULT);
    end
  end

`ifdef AUDIO_PLL_SEQ_LOSS_CNT_EN
  logic loss_evt;

  assign loss_evt = !restart && (state == RUN) && !locked_s;

  // Cleared only by reset_n; restart leaves the history intact.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lock_loss_count <= '0;
    end else if (loss_evt && (lock_loss_count != '1)) begin
      lock_loss_count <= lock_loss_count + LOSS_CNT_W'(1);
    end
  end
`else
  assign lock_loss_count = '0;
`endif

endmodule

// File: tb/tb_audio_pll_reset_sequencer.sv
// Bench for audio_pll_reset_sequencer: directed scenarios plus random lock/restart traffic vs a phase/age model.
module tb_audio_pll_reset_sequencer;

  localparam int T_PULSE   = 4;
  localparam int T_STABLE  = 8;
  localparam int T_TIMEOUT = 32;
  localparam int T_RETRIES = 2;

`ifdef AUDIO_PLL_SEQ_LOSS_CNT_EN
  localparam bit LOSS_EN = 1'b1;
`else
  localparam bit LOSS_EN = 1'b0;
`endif

  localparam int PH_PULSE = 0;
  localparam int PH_WAIT  = 1;
  localparam int PH_STAB  = 2;
  localparam int PH_RUN   = 3;
  localparam int PH_FAULT = 4;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       pll_locked;
  logic       restart;
  logic       pll_rst;
  logic       audio_reset_n;
  logic       ready;
  logic       fault;
  logic [1:0] retry_count;
  logic [7:0] lock_loss_count;

  int n_checks = 0;
  int n_errors = 0;

  int       m_phase;
  int       m_age;
  int       m_retries;
  int       m_loss;
  bit [1:0] m_hist;

  always #5 clk = ~clk;

  audio_pll_reset_sequencer #(
    .RST_PULSE_CYCLES    (T_PULSE),
    .LOCK_STABLE_CYCLES  (T_STABLE),
    .LOCK_TIMEOUT_CYCLES (T_TIMEOUT),
    .MAX_RETRIES         (T_RETRIES)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .pll_locked      (pll_locked),
    .restart         (restart),
    .pll_rst         (pll_rst),
    .audio_reset_n   (audio_reset_n),
    .ready           (ready),
    .fault           (fault),
    .retry_count     (retry_count),
    .lock_loss_count (lock_loss_count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase   = PH_PULSE;
    m_age     = 0;
    m_retries = 0;
    m_loss    = 0;
    m_hist    = 2'b00;
  endtask

  // One clock edge of the reference: phases measured by elapsed cycles counted upward.
  task automatic model_step(input logic lk, input logic rs);
    bit ls;
    ls = m_hist[1];
    if (rs) begin
      m_phase = PH_PULSE; m_age = 0; m_retries = 0;
    end else begin
      case (m_phase)
        PH_PULSE: if (m_age == T_PULSE - 1) begin m_phase = PH_WAIT; m_age = 0; end
                  else m_age++;
        PH_WAIT: begin
          if (ls) begin m_phase = PH_STAB; m_age = 0; end
          else if (m_age == T_TIMEOUT - 1) begin
            if (m_retries < T_RETRIES) begin m_retries++; m_phase = PH_PULSE; m_age = 0; end
            else m_phase = PH_FAULT;
          end else m_age++;
        end
        PH_STAB: begin
          if (!ls) begin m_phase = PH_WAIT; m_age = 0; end
          else if (m_age == T_STABLE - 1) begin m_phase = PH_RUN; m_retries = 0; end
          else m_age++;
        end
        PH_RUN: if (!ls) begin
          m_phase = PH_PULSE; m_age = 0;
          if (m_loss < 255) m_loss++;
        end
        default: ;
      endcase
    end
    m_hist = {m_hist[0], lk};
  endtask

  task automatic check_outputs();
    chk("pll_rst",   pll_rst,         32'((m_phase == PH_PULSE) || (m_phase == PH_FAULT)));
    chk("audio_rn",  audio_reset_n,   32'(m_phase == PH_RUN));
    chk("ready",     ready,           32'(m_phase == PH_RUN));
    chk("fault",     fault,           32'(m_phase == PH_FAULT));
    chk("retry_cnt", retry_count,     32'(m_retries));
    chk("loss_cnt",  lock_loss_count, LOSS_EN ? 32'(m_loss) : 32'd0);
  endtask

  // Called at a negedge; drives inputs for the coming edge and checks after it.
  task automatic tick(input logic lk, input logic rs);
    pll_locked = lk;
    restart    = rs;
    model_step(lk, rs);
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  // Called at a negedge; checks outputs mid-cycle with no edge in between.
  task automatic async_reset();
    reset_n = 1'b0;
    #1;
    model_reset();
    chk("rst_pll_rst",  pll_rst,         1);
    chk("rst_audio_rn", audio_reset_n,   0);
    chk("rst_ready",    ready,           0);
    chk("rst_fault",    fault,           0);
    chk("rst_retry",    retry_count,     0);
    chk("rst_loss",     lock_loss_count, 0);
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    check_outputs();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1);
  end

  initial begin
    int  pulses;
    int  width;
    int  n;
    bit  seen;
    bit  prev_rst;
    int  rc_at_pulse [3];
    bit  lk;
    int  run_left;

    reset_n    = 1'b1;
    pll_locked = 1'b0;
    restart    = 1'b0;
    model_reset();
    @(negedge clk);
    async_reset();

    // Clean bring-up: lock raised in cycle 10, RUN expected in cycle 21.
    chk("bringup_c0_pll_rst", pll_rst, 1);
    for (int c = 0; c < 21; c++) begin
      tick(c >= 10, 1'b0);
      if (c + 1 == 3)  chk("bringup_c3_pll_rst", pll_rst, 1);
      if (c + 1 == 4)  chk("bringup_c4_pll_rst", pll_rst, 0);
      if (c + 1 == 20) chk("bringup_c20_ready", ready, 0);
      if (c + 1 == 21) begin
        chk("bringup_c21_ready", ready, 1);
        chk("bringup_c21_audio_rn", audio_reset_n, 1);
      end
    end

    // Lock loss in RUN: audio reset reasserts on the third edge.
    tick(1'b0, 1'b0);
    chk("loss_e1_ready", ready, 1);
    tick(1'b0, 1'b0);
    chk("loss_e2_ready", ready, 1);
    tick(1'b0, 1'b0);
    chk("loss_e3_ready", ready, 0);
    chk("loss_e3_audio_rn", audio_reset_n, 0);
    chk("loss_e3_pll_rst", pll_rst, 1);
    chk("loss_e3_count", lock_loss_count, LOSS_EN ? 1 : 0);
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      tick(1'b1, 1'b0);
      seen = ready;
    end
    chk("relock_run", seen, 1);

    // Glitch in STABLE: three low cycles restart the stability count.
    tick(1'b1, 1'b1);
    for (int i = 0; i < 6; i++) tick(1'b1, 1'b0);
    chk("glitch_pre_ready", ready, 0);
    chk("glitch_pre_pll_rst", pll_rst, 0);
    for (int k = 0; k < 14; k++) begin
      tick(k >= 3, 1'b0);
      if (k + 1 <= 13) begin
        chk("glitch_no_run", ready, 0);
        chk("glitch_no_pulse", pll_rst, 0);
      end else begin
        chk("glitch_run", ready, 1);
      end
    end

    // Timeout exhaustion: three pulses with retry 0,1,2, then sticky fault.
    pulses   = 0;
    prev_rst = pll_rst;
    tick(1'b0, 1'b1);
    n = 0;
    while (!fault && n < 400) begin
      if (pll_rst && !prev_rst) begin
        if (pulses < 3) rc_at_pulse[pulses] = int'(retry_count);
        pulses++;
      end
      prev_rst = pll_rst;
      tick(1'b0, 1'b0);
      n++;
    end
    chk("timeout_fault", fault, 1);
    chk("timeout_pulses", pulses, 3);
    chk("timeout_rc0", rc_at_pulse[0], 0);
    chk("timeout_rc1", rc_at_pulse[1], 1);
    chk("timeout_rc2", rc_at_pulse[2], 2);
    for (int i = 0; i < 5; i++) tick(1'b0, 1'b0);
    chk("fault_hold_pll_rst", pll_rst, 1);
    chk("fault_hold", fault, 1);
    tick(1'b0, 1'b1);
    chk("restart_fault_clr", fault, 0);
    chk("restart_retry_clr", retry_count, 0);
    chk("restart_pll_rst", pll_rst, 1);
    width = 1;
    n = 0;
    while (pll_rst && n < 10) begin
      tick(1'b0, 1'b0);
      if (pll_rst) width++;
      n++;
    end
    chk("restart_pulse_width", width, T_PULSE);

    // Restart coinciding with a WAIT_LOCK timeout while one retry is used.
    tick(1'b0, 1'b1);
    for (int i = 0; i < 71; i++) tick(1'b0, 1'b0);
    chk("coinc_pre_retry", retry_count, 1);
    chk("coinc_pre_pll_rst", pll_rst, 0);
    tick(1'b0, 1'b1);
    chk("coinc_retry", retry_count, 0);
    chk("coinc_pll_rst", pll_rst, 1);
    chk("coinc_fault", fault, 0);

    // Asynchronous reset while in STABLE.
    tick(1'b1, 1'b1);
    for (int i = 0; i < 7; i++) tick(1'b1, 1'b0);
    chk("stable_pre_rst_pll_rst", pll_rst, 0);
    async_reset();

    // Random lock behaviour with occasional restarts and resets.
    lk = 1'b1;
    run_left = 0;
    for (int i = 0; i < 3000; i++) begin
      if (run_left == 0) begin
        lk = 1'($urandom_range(0, 1));
        run_left = lk ? int'($urandom_range(1, 60)) : int'($urandom_range(1, 130));
      end
      run_left--;
      if ($urandom_range(0, 399) == 0) async_reset();
      tick(lk, ($urandom_range(0, 79) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
